// File: rtl/aidc_lite_decomp_sr_gear_pkg.sv
// Package for the AIDC-Lite sign-reduction decompressor.
// Holds the FSM state encoding, the reduction-mode encoding and the
// sign-extension helper that the unpack logic uses.
// Used by aidc_lite_decomp_sr_gear and aidc_lite_sr_unpack.
package aidc_lite_sr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALF = 2'd2
  } sr_state_e;

  typedef enum logic {
    SR_MODE_8B = 1'b0,
    SR_MODE_4B = 1'b1
  } sr_mode_e;

  // Widest element the helper can produce; callers keep the low ELEM_W bits.
  localparam int SR_EXT_W = 64;

  // Sign-extends the low 'width' bits (1..8) of value.
  function automatic logic [SR_EXT_W-1:0] sr_sext(input logic [7:0] value, input int width);
    logic [SR_EXT_W-1:0] res;
    logic [2:0]          msb;
    msb = 3'(width - 1);
    res = {SR_EXT_W{value[msb]}};
    for (int i = 0; i < 8; i++) begin
      if (i < width) res[i] = value[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/aidc_lite_decomp_sr_gear_if.sv
// Beat-in / buffer-write-out bundle of the SR decompressor.
// master: upstream source and buffer sink (drives beats, observes writes).
// slave : the decompressor.
// Beat side : valid_i, ready_o, sop_i, eop_i, mode_i, data_i[IN_W]
// Write side: valid_o, addr_o[ADDR_W], data_o[OUT_W], done_o
// Parameters must match those of the decompressor it is bound to.
interface aidc_lite_decomp_sr_gear_if #(
  parameter int IN_W   = 32,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 4
);
  localparam int OUT_W = (IN_W / 8) * ELEM_W;

  logic              valid_i;
  logic              ready_o;
  logic              sop_i;
  logic              eop_i;
  logic              mode_i;
  logic [IN_W-1:0]   data_i;
  logic              valid_o;
  logic [ADDR_W-1:0] addr_o;
  logic [OUT_W-1:0]  data_o;
  logic              done_o;

  modport master (
    output valid_i, sop_i, eop_i, mode_i, data_i,
    input  ready_o, valid_o, addr_o, data_o, done_o
  );

  modport slave (
    input  valid_i, sop_i, eop_i, mode_i, data_i,
    output ready_o, valid_o, addr_o, data_o, done_o
  );
endinterface

// File: rtl/aidc_lite_decomp_sr_gear_unpack.sv
// Combinational element unpacker for the SR decompressor.
// Ports: i_data (beat or zero-extended half beat), i_mode (8/4-bit elements),
//        i_sop_trunc (top element loses HDR_W header bits), o_word (OUT_W).
// Element k comes from i_data[k*R +: R] and lands at o_word[k*ELEM_W +: ELEM_W].
module aidc_lite_sr_unpack
  import aidc_lite_sr_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int ELEM_W = 16,
  parameter int HDR_W  = 1
) (
  input  logic [IN_W-1:0]             i_data,
  input  sr_mode_e                    i_mode,
  input  logic                        i_sop_trunc,
  output logic [(IN_W/8)*ELEM_W-1:0]  o_word
);
  localparam int N = IN_W / 8;

  always_comb begin
    logic [7:0]          w_raw;
    int                  w_len;
    logic [SR_EXT_W-1:0] w_ext;
    o_word = '0;
    w_raw  = '0;
    w_len  = 8;
    w_ext  = '0;
    for (int k = 0; k < N; k++) begin
      if (i_mode == SR_MODE_8B) begin
        w_raw = i_data[k*8 +: 8];
        w_len = 8;
      end else begin
        w_raw = {4'b0000, i_data[k*4 +: 4]};
        w_len = 4;
      end
      // Header bits sit above the topmost element; its sign bit moves down.
      if (i_sop_trunc && (k == N - 1)) w_len = w_len - HDR_W;
      w_ext = sr_sext(w_raw, w_len);
      o_word[k*ELEM_W +: ELEM_W] = w_ext[ELEM_W-1:0];
    end
  end
endmodule

// File: rtl/aidc_lite_decomp_sr_gear.sv
// AIDC-Lite sign-reduction decompressor with 1:2 gearbox for 4-bit mode.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of
//        aidc_lite_decomp_sr_gear_if: beat input + buffer write output).
// Optional: define AIDC_LITE_SR_ERR_CHK_EN to add the sticky err_o output
//           flagging protocol violations and address wrap without eop.
// Write outputs are forced to zero when valid_o=0 because the shared
// buffer ORs the writes of all decompressors.
//
// state  | meaning
// S_IDLE | done, waiting for sop
// S_RUN  | block in progress
// S_HALF | upper half of a 4-bit beat pending
module aidc_lite_decomp_sr_gear
  import aidc_lite_sr_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 4,
  parameter int HDR_W  = 1
) (
  input  logic clk,
  input  logic rst_n,
  aidc_lite_decomp_sr_gear_if.slave bus
`ifdef AIDC_LITE_SR_ERR_CHK_EN
  ,
  output logic err_o
`endif
);
  localparam int OUT_W  = (IN_W / 8) * ELEM_W;
  localparam int HALF_W = IN_W / 2;

  sr_state_e         r_state, w_state_nxt;
  sr_mode_e          r_mode;
  sr_mode_e          w_mode;
  logic              w_acc;
  logic [HALF_W-1:0] r_hi;
  logic              r_hi_sop;
  logic              r_hi_eop;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_valid_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic [OUT_W-1:0]  r_data_o;
  logic              r_done;
  logic [IN_W-1:0]   w_unp_in;
  sr_mode_e          w_unp_mode;
  logic              w_unp_trunc;
  logic [OUT_W-1:0]  w_unp_word;

  assign w_acc  = bus.valid_i && (r_state != S_HALF);
  // The sop beat itself uses the incoming mode; it is latched for the rest.
  assign w_mode = bus.sop_i ? sr_mode_e'(bus.mode_i) : r_mode;

  // Single unpacker: the held upper half in S_HALF, otherwise the live beat.
  assign w_unp_in    = (r_state == S_HALF) ? {{(IN_W-HALF_W){1'b0}}, r_hi} : bus.data_i;
  assign w_unp_mode  = (r_state == S_HALF) ? SR_MODE_4B : w_mode;
  assign w_unp_trunc = (r_state == S_HALF) ? r_hi_sop : (bus.sop_i && (w_mode == SR_MODE_8B));

  aidc_lite_sr_unpack #(
    .IN_W   (IN_W),
    .ELEM_W (ELEM_W),
    .HDR_W  (HDR_W)
  ) u_unpack (
    .i_data      (w_unp_in),
    .i_mode      (w_unp_mode),
    .i_sop_trunc (w_unp_trunc),
    .o_word      (w_unp_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALF: w_state_nxt = r_hi_eop ? S_IDLE : S_RUN;
      default: begin
        if (w_acc) begin
          if (w_mode == SR_MODE_4B) w_state_nxt = S_HALF;
          else if (bus.eop_i)       w_state_nxt = S_IDLE;
          else if (bus.sop_i)       w_state_nxt = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode    <= SR_MODE_8B;
      r_hi      <= '0;
      r_hi_sop  <= 1'b0;
      r_hi_eop  <= 1'b0;
      r_cnt     <= '0;
      r_valid_o <= 1'b0;
      r_addr_o  <= '0;
      r_data_o  <= '0;
      r_done    <= 1'b1;
    end else begin
      r_valid_o <= 1'b0;
      r_addr_o  <= '0;
      r_data_o  <= '0;
      if (r_state == S_HALF) begin
        r_valid_o <= 1'b1;
        r_addr_o  <= r_cnt;
        r_data_o  <= w_unp_word;
        if (r_hi_eop) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end else if (w_acc) begin
        r_valid_o <= 1'b1;
        r_addr_o  <= r_cnt;
        r_data_o  <= w_unp_word;
        r_hi      <= bus.data_i[IN_W-1 -: HALF_W];
        r_hi_sop  <= bus.sop_i;
        r_hi_eop  <= bus.eop_i;
        if (bus.sop_i) r_mode <= sr_mode_e'(bus.mode_i);
        if ((w_mode == SR_MODE_8B) && bus.eop_i) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          if (bus.sop_i) r_done <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o = (r_state != S_HALF);
  assign bus.valid_o = r_valid_o;
  assign bus.addr_o  = r_addr_o;
  assign bus.data_o  = r_data_o;
  assign bus.done_o  = r_done;

`ifdef AIDC_LITE_SR_ERR_CHK_EN
  logic r_err;
  logic w_wrap;
  logic w_err_evt;

  // Counter steps past its top value without an eop clearing it.
  assign w_wrap = (r_cnt == {ADDR_W{1'b1}}) &&
                  (((r_state == S_HALF) && !r_hi_eop) ||
                   (w_acc && !((w_mode == SR_MODE_8B) && bus.eop_i)));

  assign w_err_evt = (w_acc && !bus.sop_i && (r_state == S_IDLE)) ||
                     (w_acc && bus.sop_i && (r_state == S_RUN)) ||
                     w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign err_o = r_err;
`endif
endmodule
